// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor: table geometry,
// 2-bit counter encodings and the BHT/BTB entry layout.
package bp_pkg;

    localparam int ENTRIES   = 16;
    localparam int TAG_W     = 10;
    localparam int IDX_W     = $clog2(ENTRIES);
    localparam int PC_W      = 64;
    // Widest tag any legal geometry can need; unused upper bits stay zero.
    localparam int MAX_TAG_W = PC_W - 2;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [PC_W-1:0]      target;
        cnt_t                 cnt;
    } bp_entry_t;

    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  cnt_t cur,
    input  logic taken,
    output cnt_t next
);

    // Step towards strong taken / strong not-taken, holding at the ends.
    always_comb begin
        next = cur;
        case (cur)
            CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
            default: next = CNT_WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB: combinational fetch lookup, EX-stage resolution,
// table training and saturating statistics counters.
module branch_predictor #(
    parameter int ENTRIES = bp_pkg::ENTRIES,
    parameter int TAG_W   = bp_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] if_pc,
    output logic        pred_taken,
    output logic [63:0] pred_target,
    input  logic        ex_branch,
    input  logic [63:0] ex_pc,
    input  logic        ex_taken,
    input  logic [63:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [63:0] ex_pred_target,
    output logic        mispredict,
    output logic [63:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    import bp_pkg::*;

    localparam int          IDX_BITS = $clog2(ENTRIES);
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    bp_entry_t            table_r [ENTRIES];
    bp_entry_t            if_entry_s;
    bp_entry_t            ex_entry_s;
    bp_entry_t            ex_new_entry_s;
    logic [IDX_BITS-1:0]  if_idx_s;
    logic [IDX_BITS-1:0]  ex_idx_s;
    logic [MAX_TAG_W-1:0] if_tag_s;
    logic [MAX_TAG_W-1:0] ex_tag_s;
    logic                 if_hit_s;
    logic                 ex_hit_s;
    logic                 ex_write_s;
    cnt_t                 cnt_next_s;
    logic                 mispredict_s;
    logic [31:0]          branch_count_r;
    logic [31:0]          mispredict_count_r;

    assign if_idx_s = if_pc[IDX_BITS+1:2];
    assign ex_idx_s = ex_pc[IDX_BITS+1:2];
    assign if_tag_s = MAX_TAG_W'(if_pc[IDX_BITS+2 +: TAG_W]);
    assign ex_tag_s = MAX_TAG_W'(ex_pc[IDX_BITS+2 +: TAG_W]);

    // Fetch lookup reads only registered state, so a same-cycle update is not visible.
    always_comb begin
        if_entry_s = table_r[if_idx_s];
        if_hit_s   = if_entry_s.valid && (if_entry_s.tag == if_tag_s);
        pred_taken = if_hit_s && if_entry_s.cnt[1];
        if (pred_taken) begin
            pred_target = if_entry_s.target;
        end else begin
            pred_target = pc_plus4(if_pc);
        end
    end

    // Misprediction covers both wrong direction and wrong target on a taken branch.
    always_comb begin
        mispredict_s = 1'b0;
        if (ex_branch) begin
            mispredict_s = (ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_pred_target != ex_target));
        end else begin
            mispredict_s = 1'b0;
        end
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = pc_plus4(ex_pc);
        end
    end

    assign mispredict = mispredict_s;

    bp_sat_counter u_sat_counter (
        .cur   (ex_entry_s.cnt),
        .taken (ex_taken),
        .next  (cnt_next_s)
    );

    // Training: hits update counter (and target when taken); taken misses allocate.
    always_comb begin
        ex_entry_s     = table_r[ex_idx_s];
        ex_hit_s       = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
        ex_new_entry_s = ex_entry_s;
        ex_write_s     = 1'b0;
        if (ex_branch && ex_hit_s) begin
            ex_write_s         = 1'b1;
            ex_new_entry_s.cnt = cnt_next_s;
            if (ex_taken) begin
                ex_new_entry_s.target = ex_target;
            end else begin
                ex_new_entry_s.target = ex_entry_s.target;
            end
        end else if (ex_branch && ex_taken) begin
            ex_write_s     = 1'b1;
            ex_new_entry_s = '{valid: 1'b1, tag: ex_tag_s, target: ex_target, cnt: CNT_WT};
        end else begin
            ex_write_s = 1'b0;
        end
    end

    // Table storage; reset wins over any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= '{valid: 1'b0, tag: '0, target: 64'd0, cnt: CNT_WNT};
            end
        end else if (ex_write_s) begin
            table_r[ex_idx_s] <= ex_new_entry_s;
        end else begin
            table_r[ex_idx_s] <= table_r[ex_idx_s];
        end
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else begin
            if (ex_branch && (branch_count_r != STAT_MAX)) begin
                branch_count_r <= branch_count_r + 32'd1;
            end
            if (mispredict_s && (mispredict_count_r != STAT_MAX)) begin
                mispredict_count_r <= mispredict_count_r + 32'd1;
            end
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor plus a hand-written
// asynchronous-reset-during-update sequence.
module tb_branch_predictor;

    typedef struct packed {
        logic [63:0] if_pc;
        logic        ex_branch;
        logic [63:0] ex_pc;
        logic        ex_taken;
        logic [63:0] ex_target;
        logic        ex_pred_taken;
        logic [63:0] ex_pred_target;
        logic        exp_pt;
        logic [63:0] exp_ptgt;
        logic        exp_misp;
        logic [63:0] exp_redir;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_branch;
    logic [63:0] ex_pc;
    logic        ex_taken;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    vec_t        vq[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_bc = 32'd0;
    logic [31:0] exp_mc = 32'd0;

    branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_branch        (ex_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [63:0] ipc, input logic br, input logic [63:0] epc,
                           input logic tk, input logic [63:0] tgt, input logic ppt,
                           input logic [63:0] pptgt, input logic xpt, input logic [63:0] xptgt,
                           input logic xm, input logic [63:0] xr);
        vec_t v;
        v = '{ipc, br, epc, tk, tgt, ppt, pptgt, xpt, xptgt, xm, xr};
        vq.push_back(v);
    endtask

    task automatic add_br(input logic [63:0] ipc, input logic [63:0] epc, input logic tk,
                          input logic [63:0] tgt, input logic ppt, input logic [63:0] pptgt,
                          input logic xpt, input logic [63:0] xptgt, input logic xm,
                          input logic [63:0] xr);
        add_vec(ipc, 1'b1, epc, tk, tgt, ppt, pptgt, xpt, xptgt, xm, xr);
    endtask

    task automatic add_idle(input logic [63:0] ipc, input logic xpt, input logic [63:0] xptgt);
        add_vec(ipc, 1'b0, 64'h100, 1'b0, 64'h0, 1'b0, 64'h104, xpt, xptgt, 1'b0, 64'h104);
    endtask

    task automatic drive(input vec_t v);
        if_pc          = v.if_pc;
        ex_branch      = v.ex_branch;
        ex_pc          = v.ex_pc;
        ex_taken       = v.ex_taken;
        ex_target      = v.ex_target;
        ex_pred_taken  = v.ex_pred_taken;
        ex_pred_target = v.ex_pred_target;
    endtask

    initial begin
        // Reset state, first allocation, training to strong taken, then a not-taken.
        add_idle(64'h100, 1'b0, 64'h104);
        add_br(64'h100, 64'h100, 1'b1, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b1, 64'h200);
        add_br(64'h100, 64'h100, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b0, 64'h200);
        add_br(64'h100, 64'h100, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b0, 64'h200);
        add_br(64'h100, 64'h100, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b0, 64'h200);
        add_br(64'h100, 64'h100, 1'b0, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h104);
        add_idle(64'h100, 1'b1, 64'h200);
        // Aliasing 0x140 onto the same index evicts 0x100.
        add_br(64'h140, 64'h140, 1'b1, 64'h300, 1'b0, 64'h144, 1'b0, 64'h144, 1'b1, 64'h300);
        add_idle(64'h100, 1'b0, 64'h104);
        add_idle(64'h140, 1'b1, 64'h300);
        // Right direction, wrong target; target retrained.
        add_br(64'h140, 64'h140, 1'b1, 64'h280, 1'b1, 64'h200, 1'b1, 64'h300, 1'b1, 64'h280);
        add_idle(64'h140, 1'b1, 64'h280);
        // Not-taken miss leaves the table alone.
        add_br(64'h140, 64'h200, 1'b0, 64'h0, 1'b0, 64'h204, 1'b1, 64'h280, 1'b0, 64'h204);
        add_idle(64'h140, 1'b1, 64'h280);
        // pc+4 wraps; ex_branch low masks a disagreement.
        add_idle(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
        add_vec(64'h140, 1'b0, 64'h140, 1'b1, 64'h999, 1'b0, 64'h144, 1'b1, 64'h280, 1'b0, 64'h999);
        // Walk the counter down to strong NT, then back up with a new target.
        add_br(64'h140, 64'h140, 1'b0, 64'h280, 1'b1, 64'h280, 1'b1, 64'h280, 1'b1, 64'h144);
        add_br(64'h140, 64'h140, 1'b0, 64'h280, 1'b1, 64'h280, 1'b1, 64'h280, 1'b1, 64'h144);
        add_br(64'h140, 64'h140, 1'b0, 64'h280, 1'b0, 64'h144, 1'b0, 64'h144, 1'b0, 64'h144);
        add_idle(64'h140, 1'b0, 64'h144);
        add_br(64'h140, 64'h140, 1'b1, 64'h380, 1'b0, 64'h144, 1'b0, 64'h144, 1'b1, 64'h380);
        add_idle(64'h140, 1'b0, 64'h144);
        add_br(64'h140, 64'h140, 1'b1, 64'h380, 1'b0, 64'h144, 1'b0, 64'h144, 1'b1, 64'h380);
        add_idle(64'h140, 1'b1, 64'h380);

        reset = 1'b1;
        drive(vq[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k]);
            #2;
            chk($sformatf("v%0d pred_taken", k), {63'd0, pred_taken}, {63'd0, vq[k].exp_pt});
            chk($sformatf("v%0d pred_target", k), pred_target, vq[k].exp_ptgt);
            chk($sformatf("v%0d mispredict", k), {63'd0, mispredict}, {63'd0, vq[k].exp_misp});
            chk($sformatf("v%0d redirect_pc", k), redirect_pc, vq[k].exp_redir);
            chk($sformatf("v%0d branch_count", k), {32'd0, branch_count}, {32'd0, exp_bc});
            chk($sformatf("v%0d mispredict_count", k), {32'd0, mispredict_count}, {32'd0, exp_mc});
            exp_bc = exp_bc + {31'd0, vq[k].ex_branch};
            exp_mc = exp_mc + {31'd0, vq[k].exp_misp};
        end

        @(negedge clk);
        chk("final branch_count", {32'd0, branch_count}, 64'd13);
        chk("final mispredict_count", {32'd0, mispredict_count}, 64'd8);

        // Async reset between edges while a taken branch would allocate/retrain.
        if_pc          = 64'h140;
        ex_branch      = 1'b1;
        ex_pc          = 64'h140;
        ex_taken       = 1'b1;
        ex_target      = 64'h500;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 64'h144;
        #2;
        reset = 1'b1;
        #1;
        chk("async pred_taken", {63'd0, pred_taken}, 64'd0);
        chk("async pred_target", pred_target, 64'h144);
        chk("async branch_count", {32'd0, branch_count}, 64'd0);
        chk("async mispredict_count", {32'd0, mispredict_count}, 64'd0);
        chk("async mispredict", {63'd0, mispredict}, 64'd1);
        chk("async redirect_pc", redirect_pc, 64'h500);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        ex_branch = 1'b0;
        #2;
        chk("post-reset pred_taken", {63'd0, pred_taken}, 64'd0);
        chk("post-reset pred_target", pred_target, 64'h144);
        chk("post-reset branch_count", {32'd0, branch_count}, 64'd0);
        if_pc = 64'h100;
        #1;
        chk("post-reset 0x100 pred_taken", {63'd0, pred_taken}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, 16, number of BHT/BTB entries (power of two).
REQ-002 Parameter TAG_W, 10, stored tag width taken from PC bits above the index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_pc  input  64  fetch-stage PC to predict.
REQ-006 pred_taken  output  1  fetch prediction: branch taken.
REQ-007 pred_target  output  64  predicted next PC.
REQ-008 ex_branch  input  1  EX stage holds a resolved conditional branch this cycle.
REQ-009 ex_pc  input  64  PC of the resolving branch.
REQ-010 ex_taken  input  1  actual outcome from the EX comparator (beq/blt/bgt).
REQ-011 ex_target  input  64  actual taken target computed in EX.
REQ-012 ex_pred_taken, ex_pred_target  input  1, 64  prediction carried down the pipe with the branch.
REQ-013 mispredict  output  1  prediction was wrong; flush IF/ID and ID/EX.
REQ-014 redirect_pc  output  64  corrected fetch PC, valid when mispredict=1.
REQ-015 branch_count, mispredict_count  output  32, 32  statistics counters.

Function
REQ-016 Index SHALL be PC[log2(ENTRIES)+1:2]; tag SHALL be the next TAG_W bits above the index.
REQ-017 Each entry SHALL hold valid, tag, 64-bit target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-018 Lookup SHALL be combinational from registered state: hit = valid & tag match; pred_taken = hit & counter[1]; pred_target = pred_taken ? target : if_pc+4.
REQ-019 mispredict SHALL be combinational: ex_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)); 0 when ex_branch=0.
REQ-020 redirect_pc SHALL be ex_taken ? ex_target : ex_pc+4.
REQ-021 On a clock edge with ex_branch=1 and entry hit: counter SHALL increment (saturate at 11) if ex_taken, decrement (saturate at 00) otherwise; target SHALL be written with ex_target if ex_taken.
REQ-022 On ex_branch=1, miss, ex_taken=1: entry SHALL be allocated (overwrite) with valid=1, tag, ex_target, counter=10.
REQ-023 On ex_branch=1, miss, ex_taken=0: table SHALL be unchanged.
REQ-024 Same-cycle lookup and update of the same index SHALL return the pre-update contents (no bypass).
REQ-025 branch_count SHALL increment on each edge with ex_branch=1; mispredict_count on each edge with mispredict=1; both saturate at 0xFFFF_FFFF.
REQ-026 Adders (pc+4) SHALL wrap modulo 2^64.

Reset
REQ-027 Assertion of reset SHALL immediately clear all valid bits, set all counters to 01, clear targets/tags to 0, clear both statistics counters.
REQ-028 After reset, pred_taken=0, pred_target=if_pc+4, mispredict follows REQ-019 from inputs only.
REQ-029 Reset asserted mid-update SHALL override the update; no partial entry write survives.

Structure
REQ-030 Shared package bp_pkg SHALL hold ENTRIES/TAG_W defaults, derived IDX_W, counter encodings, and the entry struct typedef.
REQ-031 Saturating 2-bit counter next-state logic SHALL be a sub-module bp_sat_counter (inputs: cur, taken; output: next).
REQ-032 Table storage SHALL be flops (no SRAM macro).

Verification
REQ-033 Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, counts 0.
REQ-034 Branch ex_pc=0x100 taken to 0x200, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x200; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-035 Same branch taken 3 more times then not taken once -> counter 11 then 10, still predicts taken; mispredict=1 on the not-taken, redirect_pc=0x104.
REQ-036 Aliasing: entry for 0x100 valid, if_pc=0x140 (same index, different tag) -> pred_taken=0; taken branch at 0x140 to 0x300 overwrites entry, 0x100 then misses.
REQ-037 Taken branch with correct direction but ex_pred_target=0x200, ex_target=0x280 -> mispredict=1, redirect_pc=0x280, stored target becomes 0x280.
REQ-038 Async reset asserted between edges while ex_branch=1 -> table and counters cleared without waiting for clk; update not applied.
